// File: rtl/pcs_sync_pkg.sv
// pcs_sync_pkg: shared state encoding and comma constants for the multilane PCS sync block
package pcs_sync_pkg;
  typedef enum logic [1:0] {
    LOSS_OF_SYNC,
    COMMA_DETECT,
    ACQUIRE_SYNC,
    SYNC_ACQUIRED
  } sync_state_e;
  localparam logic [6:0] COMMA_P = 7'b0011111;
  localparam logic [6:0] COMMA_N = 7'b1100000;
  localparam logic [9:0] K28_5_P = 10'b0011111010;
  localparam logic [9:0] K28_5_N = 10'b1100000101;
  function automatic logic is_comma(input logic [9:0] cg);
    return cg[9:3] == COMMA_P || cg[9:3] == COMMA_N;
  endfunction
endpackage

// File: rtl/pcs_sync_lane.sv
// pcs_sync_lane: one lane's comma sync FSM, bad/good counters and output registers (loss_cnt with PCS_SYNC_LOSS_CNT_EN)
module pcs_sync_lane
  import pcs_sync_pkg::*;
#(
  parameter int ACQ_COMMAS   = 3,
  parameter int GOOD_CGS     = 4,
  parameter int LOSS_BAD_CGS = 4
) (
  input  logic       clock,
  input  logic       mr_main_reset,
  input  logic       sig_ok,
  input  logic [9:0] rx_code_group,
  input  logic       cg_invalid,
  output logic [9:0] sudi,
  output logic       rx_even,
  output logic       code_sync_status
`ifdef PCS_SYNC_LOSS_CNT_EN
  ,output logic [7:0] loss_cnt
`endif
);
  localparam int CW = $clog2(ACQ_COMMAS + 1);
  localparam int GW = $clog2(GOOD_CGS + 1);
  localparam int BW = $clog2(LOSS_BAD_CGS + 1);
  sync_state_e state;
  logic [CW-1:0] comma_cnt;
  logic [GW-1:0] good;
  logic [BW-1:0] bad;
  logic comma, pos_even, cgbad;
  assign comma = is_comma(rx_code_group);
  assign pos_even = (state == COMMA_DETECT) ? 1'b0 : !rx_even;
  assign cgbad = cg_invalid | (comma & !pos_even);
  assign code_sync_status = state == SYNC_ACQUIRED;
  // sync FSM: state, even/odd tracking, comma and bad/good counters, SUDI register
  always_ff @(posedge clock) begin
    if (mr_main_reset) begin
      state <= LOSS_OF_SYNC;
      rx_even <= 1'b0;
      sudi <= '0;
      comma_cnt <= '0;
      good <= '0;
      bad <= '0;
    end else begin
      sudi <= rx_code_group;
      rx_even <= !rx_even;
      if (!sig_ok) state <= LOSS_OF_SYNC;
      else begin
        unique case (state)
          LOSS_OF_SYNC: if (comma) begin
            state <= COMMA_DETECT;
            rx_even <= 1'b1;
            comma_cnt <= CW'(1);
          end
          COMMA_DETECT: begin
            rx_even <= 1'b0;
            state <= (!cgbad && !comma) ? ACQUIRE_SYNC : LOSS_OF_SYNC;
          end
          ACQUIRE_SYNC: begin
            if (cgbad) state <= LOSS_OF_SYNC;
            else if (comma) begin
              rx_even <= 1'b1;
              if (int'(comma_cnt) + 1 >= ACQ_COMMAS) begin
                state <= SYNC_ACQUIRED;
                good <= '0;
                bad <= '0;
              end else begin
                comma_cnt <= comma_cnt + CW'(1);
                state <= COMMA_DETECT;
              end
            end
          end
          SYNC_ACQUIRED: begin
            if (cgbad) begin
              good <= '0;
              bad <= bad + BW'(1);
              if (int'(bad) + 1 >= LOSS_BAD_CGS) state <= LOSS_OF_SYNC;
            end else if (bad != '0) begin
              good <= (int'(good) + 1 >= GOOD_CGS) ? '0 : good + GW'(1);
              bad <= (int'(good) + 1 >= GOOD_CGS) ? bad - BW'(1) : bad;
            end
          end
          default: state <= LOSS_OF_SYNC;
        endcase
      end
    end
  end
`ifdef PCS_SYNC_LOSS_CNT_EN
  logic drop;
  assign drop = state == SYNC_ACQUIRED && (!sig_ok || (cgbad && int'(bad) + 1 >= LOSS_BAD_CGS));
  // saturating count of SYNC_ACQUIRED -> LOSS_OF_SYNC transitions
  always_ff @(posedge clock) begin
    if (mr_main_reset) loss_cnt <= '0;
    else if (drop && loss_cnt != 8'hff) loss_cnt <= loss_cnt + 8'd1;
  end
`endif
endmodule

// File: rtl/pcs_sync_multilane.sv
// pcs_sync_multilane: N independent 1000BASE-X style sync lanes plus all_sync (loss_cnt port with PCS_SYNC_LOSS_CNT_EN)
module pcs_sync_multilane
  import pcs_sync_pkg::*;
#(
  parameter int LANES        = 1,
  parameter int ACQ_COMMAS   = 3,
  parameter int GOOD_CGS     = 4,
  parameter int LOSS_BAD_CGS = 4
) (
  input  logic                  clock,
  input  logic                  mr_main_reset,
  input  logic                  mr_loopback,
  input  logic [LANES-1:0]      signal_detect,
  input  logic [LANES*10-1:0]   rx_code_group,
  input  logic [LANES-1:0]      cg_invalid,
  output logic [LANES*10-1:0]   SUDI,
  output logic [LANES-1:0]      code_sync_status,
  output logic [LANES-1:0]      rx_even,
  output logic                  all_sync
`ifdef PCS_SYNC_LOSS_CNT_EN
  ,output logic [LANES*8-1:0]   loss_cnt
`endif
);
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pcs_sync_lane #(
      .ACQ_COMMAS(ACQ_COMMAS),
      .GOOD_CGS(GOOD_CGS),
      .LOSS_BAD_CGS(LOSS_BAD_CGS)
    ) u_lane (
      .clock(clock),
      .mr_main_reset(mr_main_reset),
      .sig_ok(signal_detect[i] | mr_loopback),
      .rx_code_group(rx_code_group[10*i +: 10]),
      .cg_invalid(cg_invalid[i]),
      .sudi(SUDI[10*i +: 10]),
      .rx_even(rx_even[i]),
      .code_sync_status(code_sync_status[i])
`ifdef PCS_SYNC_LOSS_CNT_EN
      ,.loss_cnt(loss_cnt[8*i +: 8])
`endif
    );
  end
  assign all_sync = &code_sync_status;
endmodule

// File: tb/tb_pcs_sync_multilane.sv
// tb_pcs_sync_multilane: randomized + directed scoreboard bench for pcs_sync_multilane (optional PCS_SYNC_LOSS_CNT_EN checks)
module tb_pcs_sync_multilane;
  localparam int L = 4;
  localparam int ACQ = 3;
  localparam int GOOD = 4;
  localparam int LOSS = 4;
  localparam logic [9:0] K_P = 10'b0011111010;
  localparam logic [9:0] D162 = 10'b0110110101;
  logic clock = 1'b0;
  logic mr_main_reset = 1'b1;
  logic mr_loopback = 1'b0;
  logic [L-1:0] signal_detect = '1;
  logic [L-1:0] cg_invalid = '0;
  logic [L*10-1:0] rx_code_group = '0;
  logic [L*10-1:0] SUDI;
  logic [L-1:0] code_sync_status, rx_even;
  logic all_sync;
`ifdef PCS_SYNC_LOSS_CNT_EN
  logic [L*8-1:0] loss_cnt;
`endif
  always #5 clock = ~clock;
  pcs_sync_multilane #(.LANES(L), .ACQ_COMMAS(ACQ), .GOOD_CGS(GOOD), .LOSS_BAD_CGS(LOSS)) dut (
    .clock(clock),
    .mr_main_reset(mr_main_reset),
    .mr_loopback(mr_loopback),
    .signal_detect(signal_detect),
    .rx_code_group(rx_code_group),
    .cg_invalid(cg_invalid),
    .SUDI(SUDI),
    .code_sync_status(code_sync_status),
    .rx_even(rx_even),
    .all_sync(all_sync)
`ifdef PCS_SYNC_LOSS_CNT_EN
    ,.loss_cnt(loss_cnt)
`endif
  );
  int checks = 0;
  int failures = 0;
  // reference lane: phase 0 hunting, 1 first comma seen, 2 acquiring, 3 locked
  typedef struct {int phase; bit even; int commas; int good; int bad; int losses;} lane_m;
  typedef struct {logic [L*10-1:0] sudi; logic [L-1:0] even; logic [L-1:0] stat; logic all; logic [L*8-1:0] loss;} exp_t;
  lane_m m[L];
  exp_t q[$];
  exp_t mon_e;
  bit ph = 1'b0;
  function automatic bit comma_of(logic [9:0] c);
    return c[9:3] == 7'b0011111 || c[9:3] == 7'b1100000;
  endfunction
  task automatic chk(string n, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", n, got, exp, $time);
    end
  endtask
  task automatic lose(int i);
    if (m[i].phase == 3 && m[i].losses < 255) m[i].losses++;
    m[i].phase = 0;
  endtask
  task automatic model_lane(int i, logic [9:0] c, bit inv, bit sig);
    bit k, pe, bad;
    k = comma_of(c);
    pe = !m[i].even;
    bad = inv || (k && !pe);
    if (!sig) begin
      lose(i);
      m[i].even = pe;
    end else if (m[i].phase == 0) begin
      m[i].even = k ? 1'b1 : pe;
      if (k) begin m[i].phase = 1; m[i].commas = 1; end
    end else if (m[i].phase == 1) begin
      m[i].even = 1'b0;
      m[i].phase = (!inv && !k) ? 2 : 0;
    end else if (m[i].phase == 2) begin
      m[i].even = pe;
      if (bad) m[i].phase = 0;
      else if (k) begin
        m[i].commas++;
        if (m[i].commas >= ACQ) begin m[i].phase = 3; m[i].good = 0; m[i].bad = 0; end
        else m[i].phase = 1;
      end
    end else begin
      m[i].even = pe;
      if (bad) begin
        m[i].good = 0;
        m[i].bad++;
        if (m[i].bad >= LOSS) lose(i);
      end else if (m[i].bad > 0) begin
        m[i].good++;
        if (m[i].good >= GOOD) begin m[i].bad--; m[i].good = 0; end
      end
    end
  endtask
  task automatic cyc(input logic [L*10-1:0] cg, input logic [L-1:0] inv, input logic [L-1:0] sd, input bit lb, input bit rst);
    exp_t e;
    @(negedge clock);
    rx_code_group = cg;
    cg_invalid = inv;
    signal_detect = sd;
    mr_loopback = lb;
    mr_main_reset = rst;
    for (int i = 0; i < L; i++) begin
      if (rst) m[i] = '{default: 0};
      else model_lane(i, cg[10*i +: 10], inv[i], sd[i] | lb);
      e.sudi[10*i +: 10] = rst ? 10'd0 : cg[10*i +: 10];
      e.even[i] = m[i].even;
      e.stat[i] = m[i].phase == 3;
      e.loss[8*i +: 8] = 8'(m[i].losses);
    end
    e.all = &e.stat;
    q.push_back(e);
  endtask
  task automatic idle(int n, input logic [L-1:0] inv, input logic [L-1:0] sd, input bit lb);
    repeat (n) begin
      cyc({L{ph ? D162 : K_P}}, inv, sd, lb, 1'b0);
      ph = !ph;
    end
  endtask
  task automatic settle;
    @(posedge clock);
    #1;
  endtask
  // scoreboard monitor: one expected entry per registered output cycle
  always @(posedge clock) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      for (int i = 0; i < L; i++) begin
        chk($sformatf("sudi%0d", i), SUDI[10*i +: 10], mon_e.sudi[10*i +: 10]);
        chk($sformatf("rx_even%0d", i), rx_even[i], mon_e.even[i]);
        chk($sformatf("status%0d", i), code_sync_status[i], mon_e.stat[i]);
`ifdef PCS_SYNC_LOSS_CNT_EN
        chk($sformatf("loss_cnt%0d", i), loss_cnt[8*i +: 8], mon_e.loss[8*i +: 8]);
`endif
      end
      chk("all_sync", all_sync, mon_e.all);
    end
  end
  int p2a[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
  int p2b[8] = '{1, 0, 0, 0, 0, 1, 1, 1};
  initial begin
    cyc('0, '0, '1, 1'b0, 1'b1);
    cyc({L{K_P}}, '0, '1, 1'b0, 1'b1);
    settle();
    chk("reset_status", code_sync_status, 0);
    chk("reset_sudi", SUDI, 0);
    chk("reset_even", rx_even, 0);
    ph = 1'b0;
    idle(4, '0, '1, 1'b0);
    settle();
    chk("before_3rd_comma", code_sync_status[0], 0);
    idle(1, '0, '1, 1'b0);
    settle();
    chk("sync_on_3rd_comma", code_sync_status[0], 1);
    chk("even_on_comma", rx_even[0], 1);
    chk("sudi_comma", SUDI[9:0], K_P);
    idle(6, '0, '1, 1'b0);
    for (int j = 0; j < 8; j++) idle(1, {3'b0, p2a[j] == 1}, '1, 1'b0);
    settle();
    chk("drop_on_4th_bad", code_sync_status[0], 0);
    idle(8, '0, '1, 1'b0);
    for (int j = 0; j < 8; j++) idle(1, {3'b0, p2b[j] == 1}, '1, 1'b0);
    settle();
    chk("bad_recovered_stays", code_sync_status[0], 1);
    idle(1, '0, 4'b1110, 1'b0);
    settle();
    chk("sigdet_drop", code_sync_status[0], 0);
    idle(8, '0, '1, 1'b0);
    idle(1, '0, 4'b1110, 1'b1);
    settle();
    chk("loopback_holds", code_sync_status[0], 1);
    idle(1, '0, 4'b1110, 1'b0);
    cyc({L{K_P}}, '0, '1, 1'b0, 1'b0);
    cyc({L{D162}}, '0, '1, 1'b0, 1'b0);
    cyc({L{D162}}, '0, '1, 1'b0, 1'b0);
    cyc({L{K_P}}, '0, '1, 1'b0, 1'b0);
    ph = 1'b0;
    idle(4, '0, '1, 1'b0);
    settle();
    chk("odd_comma_restart", code_sync_status[0], 0);
    idle(1, '0, '1, 1'b0);
    settle();
    chk("reacquire_3_commas", code_sync_status[0], 1);
    idle(10, '0, '1, 1'b0);
    idle(6, 4'b0100, '1, 1'b0);
    settle();
    chk("lane2_status", code_sync_status, 4'b1011);
    chk("lane2_all_sync", all_sync, 0);
    cyc('0, '0, '1, 1'b0, 1'b1);
    ph = 1'b0;
    idle(3, '0, '1, 1'b0);
    cyc({L{K_P}}, '0, '1, 1'b0, 1'b1);
    settle();
    chk("midreset_sudi", SUDI, 0);
    chk("midreset_even", rx_even, 0);
    chk("midreset_status", {all_sync, code_sync_status}, 0);
    for (int n = 0; n < 600; n++) begin
      logic [L*10-1:0] cg;
      logic [L-1:0] inv, sd;
      for (int i = 0; i < L; i++) begin
        cg[10*i +: 10] = ($urandom % 4 == 0) ? 10'($urandom) : (ph ? D162 : K_P);
        inv[i] = $urandom % 20 == 0;
        sd[i] = $urandom % 40 != 0;
      end
      cyc(cg, inv, sd, $urandom % 8 == 0, $urandom % 200 == 0);
      ph = !ph;
    end
`ifdef PCS_SYNC_LOSS_CNT_EN
    cyc('0, '0, '1, 1'b0, 1'b1);
    for (int n = 0; n < 300; n++) begin
      idle(6, '0, '1, 1'b0);
      idle(1, '0, 4'b1110, 1'b0);
    end
    settle();
    chk("loss_cnt_sat", loss_cnt[7:0], 8'hff);
    cyc('0, '0, '1, 1'b0, 1'b1);
    settle();
    chk("loss_cnt_clear", loss_cnt, 0);
`endif
    repeat (3) @(posedge clock);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
